bus_port_fifo: RTL
==================

Name: bus_port_fifo

Overview:
Per-device input port that sits directly upstream of the shared bus handler: one instance per driver.
- The device side pushes packets into it.
- It filters packets with illegal destinations and buffers them in a first-word-fall-through FIFO.
- It presents the head packet and a pending flag to the bus handler, which pops it when the bus is granted.
- Overflow and error status are exported for the checker/scoreboard path.

Parameters:
PCKG_SZ, 16, packet width in bits; bits [PCKG_SZ-1:PCKG_SZ-8] are the destination ID, the rest is payload
DRVRS, 4, number of devices on the bus; legal unicast IDs are 0..DRVRS-1
DEPTH, 8, FIFO depth in packets; power of 2, >= 2
ID, 0, this port's own device ID

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  device writes D_push this cycle
D_push  input  PCKG_SZ  packet from device
pop  input  1  bus handler consumes head packet this cycle
D_pop  output  PCKG_SZ  head packet (FWFT), 0 when empty
pndng  output  1  FIFO non-empty
full  output  1  count == DEPTH
count  output  $clog2(DEPTH+1)  packets stored
overflow  output  1  sticky: push dropped because full
clr_ovf  input  1  clears overflow
bad_dest  output  1  one-cycle pulse: pushed packet dropped for illegal destination
pop_err  output  1  one-cycle pulse: pop while empty

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (asserted at any time, including mid-transfer):
  - Read/write pointers and count go to 0 immediately.
  - pndng=0, full=0, overflow=0, bad_dest=0, pop_err=0, D_pop=0.
  - Memory contents are don't-care.
  - The first push honoured is on the first rising edge after deassertion.
- Destination check, applied to push only:
  - dest = D_push[PCKG_SZ-1:PCKG_SZ-8].
  - Legal: dest == 8'hFF (broadcast), or dest < DRVRS and dest != ID.
  - Illegal: packet not written, count unchanged, bad_dest=1 for the following cycle.
  - An illegal push never sets overflow.
- Write:
  - A legal push with count < DEPTH writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - Latency: a push into an empty FIFO gives pndng=1 and D_pop=packet in the next cycle.
- Read:
  - pop with pndng=1 advances rd_ptr modulo DEPTH.
  - D_pop always combinationally reflects mem[rd_ptr] when count > 0, else 0.
- pop with count == 0: ignored; pop_err=1 next cycle.
- Simultaneous legal push and pop:
  - count > 0: both performed, count unchanged. This includes count == DEPTH: the push is accepted because the pop frees a slot, and overflow is not set.
  - count == 0: the pop is an error (pop_err pulse) and the push is written.
- Legal push with count == DEPTH and no pop: packet dropped; overflow set next cycle.
- overflow stays 1 until clr_ovf. If clr_ovf and a new overflow occur in the same cycle, overflow remains 1.
- Pointers wrap without special casing; count is the sole source of full/empty (no pointer-equality ambiguity).
- full = (count == DEPTH) and pndng = (count != 0), both derived from registered count.
- Width rule: count is $clog2(DEPTH+1) bits; it never exceeds DEPTH.

Decomposition:
- Shared package bus_pkg holds:
  - BCAST_ID = 8'hFF
  - DEST_W = 8
  - function get_dest(pkt) returning the top DEST_W bits
  - typedef pkt_t as logic [PCKG_SZ-1:0], parameterised via the package default of 16
- The same package is used by the bus handler and the testbench agent/checker for packet construction.
- One sub-module, fifo_core: pointers, count, memory, FWFT read, pop_err.
- bus_port_fifo wraps fifo_core and adds the destination filter, overflow sticky logic and bad_dest.

Test Plan:
- Reset, then push 0x01AA (dest 1, ID=0) on an empty FIFO: next cycle pndng=1, D_pop=0x01AA, count=1.
- Push 8 legal packets 0x0101..0x0108, then a ninth, 0x0109, with no pop: full=1, count=8, overflow=1. Pop 8 times: D_pop sequence is 0x0101..0x0108 (ninth lost), then pndng=0 and D_pop=0.
- With full=1, push 0x02BB and pop in the same cycle: count stays 8, overflow=0, and 0x02BB emerges last.
- Destination filtering:
  - Push 0x00CC (self, ID=0): dropped, bad_dest pulse.
  - Push 0x05DD (dest 5 >= DRVRS): dropped, bad_dest pulse.
  - Push 0xFFEE (broadcast): accepted, count=1.
- Pop on an empty FIFO: pop_err pulses, count stays 0. Fill to 5 and assert rst_n=0 mid-cycle: count=0, pndng=0, D_pop=0 without waiting for clk.
- Wrap-around: 20 interleaved push/pop pairs, each push followed by a pop. Data order is preserved across pointer wrap; count never exceeds 1.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: destination field layout, broadcast ID and packet type.
// Used by the port FIFO, the bus handler and the bench for packet construction.
package bus_pkg;
    localparam int          PCKG_SZ_DEF = 16;
    localparam int          DEST_W      = 8;
    localparam logic [7:0]  BCAST_ID    = 8'hFF;

    typedef logic [PCKG_SZ_DEF-1:0] pkt_t;

    function automatic logic [DEST_W-1:0] get_dest(input pkt_t pkt);
        return pkt[PCKG_SZ_DEF-1 -: DEST_W];
    endfunction
endpackage

// File: rtl/fifo_core.sv
// First-word-fall-through packet FIFO: pointers, occupancy count, storage and pop_err.
// The occupancy count alone decides full/empty, so the pointers wrap freely.
module fifo_core #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       pndng,
    output logic                       full,
    output logic                       pop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_ok, rd_ok;

    assign pndng = (count != '0);
    assign full  = (count == DEPTH_C);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign rd_ok = rd_en && pndng;
    assign wr_ok = wr_en && (!full || rd_ok);

    assign rd_data = pndng ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pop_err <= 1'b0;
        end else begin
            pop_err <= rd_en && !pndng;
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bus_port_fifo.sv
// Per-device input port ahead of the bus handler: destination filter, FWFT buffer,
// sticky overflow and one-cycle bad_dest / pop_err status pulses.
module bus_port_fifo
    import bus_pkg::*;
#(
    parameter int PCKG_SZ = 16,
    parameter int DRVRS   = 4,
    parameter int DEPTH   = 8,
    parameter int ID      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [PCKG_SZ-1:0]         D_push,
    input  logic                       pop,
    output logic [PCKG_SZ-1:0]         D_pop,
    output logic                       pndng,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic                       bad_dest,
    output logic                       pop_err
);
    logic [DEST_W-1:0] dest;
    logic              legal, push_ok, drop;

    assign dest    = D_push[PCKG_SZ-1 -: DEST_W];
    assign legal   = (dest == BCAST_ID) ||
                     ((dest < DEST_W'(DRVRS)) && (dest != DEST_W'(ID)));
    assign push_ok = push && legal;
    // Only a legal push can overflow; a same-cycle pop makes room.
    assign drop    = push_ok && full && !pop;

    fifo_core #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_ok),
        .wr_data (D_push),
        .rd_en   (pop),
        .rd_data (D_pop),
        .count   (count),
        .pndng   (pndng),
        .full    (full),
        .pop_err (pop_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            bad_dest <= 1'b0;
        end else begin
            bad_dest <= push && !legal;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end
endmodule
